// File: rtl/module_acc_array.sv
// module_acc_array
// ----------------
// N-lane partial-sum accumulator for the convolution datapath. Every lane
// owns a DEPTH-entry RAM of signed AW-bit partial sums. Each input beat adds
// the incoming PE value of every lane to the stored sum at in_addr and writes
// the new sum back. On the final pass the new sums are also streamed out.
//
// Pipeline:
//   S0 (accept edge) : beat registered into stage 1, RAM read issued
//   S1               : RAM read data available, forwarding picks prev
//   S2               : add + saturate/wrap, RAM write-back, outputs registered
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (RAM contents are kept)
//   in_valid   input beat present this cycle
//   first_pass stored sum is ignored (treated as 0)
//   last_pass  the sum produced by this beat is emitted on out_*
//   data_zero  in_data is ignored (treated as 0) for all lanes
//   in_addr    pixel address, must be < DEPTH
//   in_data    lane i at [i*DW +: DW], signed
//   out_valid  one-cycle strobe per last_pass beat
//   out_addr   address of the emitted sums
//   out_data   lane i at [i*AW +: AW], signed
//   ovf_flag   sticky per-lane saturation/overflow flag, cleared by rst only
module module_acc_array #(
    parameter int CH       = 8,
    parameter int DW       = 15,
    parameter int AW       = 20,
    parameter int DEPTH    = 114 * 114,
    parameter int ADDR_BIT = 14,
    parameter int SAT_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                first_pass,
    input  logic                last_pass,
    input  logic                data_zero,
    input  logic [ADDR_BIT-1:0] in_addr,
    input  logic [CH*DW-1:0]    in_data,
    output logic                out_valid,
    output logic [ADDR_BIT-1:0] out_addr,
    output logic [CH*AW-1:0]    out_data,
    output logic [CH-1:0]       ovf_flag
);

    localparam logic signed [AW-1:0] SUM_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SUM_MIN = {1'b1, {(AW-1){1'b0}}};

    // All lanes share one address, so the per-lane RAMs are one wide array.
    logic [CH*AW-1:0] mem [DEPTH];
    logic [CH*AW-1:0] ram_q;

    // Stage 1: beat waiting for its RAM read data
    logic                s1_valid;
    logic                s1_first;
    logic                s1_last;
    logic                s1_zero;
    logic [ADDR_BIT-1:0] s1_addr;
    logic [CH*DW-1:0]    s1_data;

    // Stage 2: beat being summed and written back
    logic                s2_valid;
    logic                s2_first;
    logic                s2_last;
    logic                s2_zero;
    logic [ADDR_BIT-1:0] s2_addr;
    logic [CH*DW-1:0]    s2_data;
    logic [CH*AW-1:0]    s2_prev;

    // Copy of the write performed on the previous edge
    logic                wr_valid_q;
    logic [ADDR_BIT-1:0] wr_addr_q;
    logic [CH*AW-1:0]    wr_data_q;

    logic [CH*AW-1:0]    wr_data;
    logic [CH-1:0]       lane_ovf;
    logic [CH*AW-1:0]    fwd_prev;

    logic signed [DW-1:0] lane_in;
    logic signed [AW-1:0] lane_prev;
    logic signed [AW-1:0] lane_cur;
    logic signed [AW:0]   lane_sum;

    // The RAM read issued on the accept edge uses read-first semantics, so
    // it can miss the write landing on the same edge and the write from the
    // stage directly ahead. Both cases are patched here; the younger S2
    // result wins over the registered older write.
    always_comb begin
        fwd_prev = ram_q;
        if (s2_valid && (s2_addr == s1_addr)) begin
            fwd_prev = wr_data;
        end else if (wr_valid_q && (wr_addr_q == s1_addr)) begin
            fwd_prev = wr_data_q;
        end
    end

    // Per-lane add in AW+1 bits. A result whose top two bits differ does
    // not fit in AW signed bits: clamp it or let it wrap, and flag the lane.
    always_comb begin
        wr_data   = '0;
        lane_ovf  = '0;
        lane_in   = '0;
        lane_prev = '0;
        lane_cur  = '0;
        lane_sum  = '0;
        for (int i = 0; i < CH; i++) begin
            lane_in   = s2_data[i*DW +: DW];
            lane_prev = s2_first ? '0 : s2_prev[i*AW +: AW];
            lane_cur  = s2_zero ? '0 : AW'(lane_in);
            lane_sum  = (AW+1)'(lane_prev) + (AW+1)'(lane_cur);
            if (lane_sum[AW] != lane_sum[AW-1]) begin
                lane_ovf[i] = 1'b1;
                if (SAT_EN != 0) begin
                    wr_data[i*AW +: AW] = lane_sum[AW] ? SUM_MIN : SUM_MAX;
                end else begin
                    wr_data[i*AW +: AW] = lane_sum[AW-1:0];
                end
            end else begin
                wr_data[i*AW +: AW] = lane_sum[AW-1:0];
            end
        end
    end

    // Partial-sum RAM: synchronous read, write-back from S2. A beat caught
    // in S2 during reset is discarded and never reaches the RAM.
    always_ff @(posedge clk) begin
        if (!rst && s2_valid) begin
            mem[s2_addr] <= wr_data;
        end
        ram_q <= mem[in_addr];
    end

    // Valid bits and architectural outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            wr_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            ovf_flag   <= '0;
        end else begin
            s1_valid   <= in_valid;
            s2_valid   <= s1_valid;
            wr_valid_q <= s2_valid;
            out_valid  <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                out_addr <= s2_addr;
                out_data <= wr_data;
            end
            if (s2_valid) begin
                ovf_flag <= ovf_flag | lane_ovf;
            end
        end
    end

    // Payload registers; meaningless whenever the matching valid bit is low
    always_ff @(posedge clk) begin
        s1_first  <= first_pass;
        s1_last   <= last_pass;
        s1_zero   <= data_zero;
        s1_addr   <= in_addr;
        s1_data   <= in_data;
        s2_first  <= s1_first;
        s2_last   <= s1_last;
        s2_zero   <= s1_zero;
        s2_addr   <= s1_addr;
        s2_data   <= s1_data;
        s2_prev   <= fwd_prev;
        wr_addr_q <= s2_addr;
        wr_data_q <= wr_data;
    end

endmodule

// File: tb/tb_module_acc_array.sv
// tb_module_acc_array
// -------------------
// Bench for module_acc_array. A default-parameter instance (8 lanes, 15-bit
// in, 20-bit saturating sums) is driven with the directed sequences and a
// random run; a small 4-lane/8-bit/12-bit instance checks lane packing.
// Expected sums come from a behavioural per-address model and are queued
// when a last_pass beat is driven; the output monitors pop and compare them.
module tb_module_acc_array;

    localparam int CH   = 8;
    localparam int DW   = 15;
    localparam int AW   = 20;
    localparam int SMAX = (1 << (AW - 1)) - 1;
    localparam int SMIN = -(1 << (AW - 1));

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, first_pass, last_pass, data_zero;
    logic [13:0]      in_addr;
    logic [CH*DW-1:0] in_data;
    logic             out_valid;
    logic [13:0]      out_addr;
    logic [CH*AW-1:0] out_data;
    logic [CH-1:0]    ovf_flag;

    logic             in_valid_b, first_pass_b, last_pass_b, data_zero_b;
    logic [3:0]       in_addr_b;
    logic [31:0]      in_data_b;
    logic             out_valid_b;
    logic [3:0]       out_addr_b;
    logic [47:0]      out_data_b;
    logic [3:0]       ovf_flag_b;

    typedef struct {
        logic [13:0]      addr;
        logic [CH*AW-1:0] data;
        logic [CH-1:0]    ovf;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [47:0] data;
    } exp_b_t;

    exp_t   sb_q[$];
    exp_b_t sb_b[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic signed [AW-1:0] mdl_mem [64][CH];
    logic [CH-1:0]        mdl_ovf;

    module_acc_array dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .first_pass (first_pass),
        .last_pass  (last_pass),
        .data_zero  (data_zero),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .ovf_flag   (ovf_flag)
    );

    module_acc_array #(
        .CH       (4),
        .DW       (8),
        .AW       (12),
        .DEPTH    (16),
        .ADDR_BIT (4),
        .SAT_EN   (1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_b),
        .first_pass (first_pass_b),
        .last_pass  (last_pass_b),
        .data_zero  (data_zero_b),
        .in_addr    (in_addr_b),
        .in_data    (in_data_b),
        .out_valid  (out_valid_b),
        .out_addr   (out_addr_b),
        .out_data   (out_data_b),
        .ovf_flag   (ovf_flag_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one beat into the main instance and advances the model; a
    // last_pass beat queues its sums, sticky flags and expected out cycle.
    task automatic applyStimulus(input bit first, input bit last, input bit zero,
                                 input int addr, input int ld[CH]);
        exp_t e;
        int   prev, cur, s;
        in_valid   = 1'b1;
        first_pass = first;
        last_pass  = last;
        data_zero  = zero;
        in_addr    = 14'(addr);
        e.data     = '0;
        for (int i = 0; i < CH; i++) begin
            in_data[i*DW +: DW] = DW'(ld[i]);
            prev = first ? 0 : int'(mdl_mem[addr][i]);
            cur  = zero ? 0 : ld[i];
            s    = prev + cur;
            if (s > SMAX) begin
                s = SMAX;
                mdl_ovf[i] = 1'b1;
            end else if (s < SMIN) begin
                s = SMIN;
                mdl_ovf[i] = 1'b1;
            end
            mdl_mem[addr][i]    = AW'(s);
            e.data[i*AW +: AW] = AW'(s);
        end
        if (last) begin
            e.addr = 14'(addr);
            e.ovf  = mdl_ovf;
            e.cyc  = cyc + 3;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        first_pass = 1'b0;
        last_pass  = 1'b0;
        data_zero  = 1'b0;
    endtask

    // Main-instance output monitor
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_addr", out_addr, e.addr);
                checkOutput("ovf_flag", ovf_flag, e.ovf);
                checkOutput("latency", cyc, e.cyc);
            end
        end
    end

    // Small-instance output monitor
    always @(negedge clk) begin
        exp_b_t eb;
        if (out_valid_b) begin
            if (sb_b.size() == 0) begin
                checkOutput("spurious_out_b", 1, 0);
            end else begin
                eb = sb_b.pop_front();
                checkOutput("out_data_b", out_data_b, eb.data);
                checkOutput("out_addr_b", out_addr_b, eb.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int     ld[CH];
        int     pos[CH];
        int     neg[CH];
        int     bvals[4];
        bit     touched[4];
        int     a;
        exp_b_t eb;

        rst         = 1'b1;
        in_valid    = 1'b0;
        first_pass  = 1'b0;
        last_pass   = 1'b0;
        data_zero   = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        in_valid_b  = 1'b0;
        first_pass_b = 1'b0;
        last_pass_b = 1'b0;
        data_zero_b = 1'b0;
        in_addr_b   = '0;
        in_data_b   = '0;
        mdl_ovf     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_addr", out_addr, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_ovf", ovf_flag, 0);
        checkOutput("reset_out_data_b", out_data_b, 0);

        // Back-to-back accumulation on one address
        applyStimulus(1, 0, 0, 5, '{100, 1, -1, 7, 0, -9, 300, -16384});
        applyStimulus(0, 0, 0, 5, '{200, 2, -2, 7, 5, -9, 300, -16384});
        applyStimulus(0, 1, 0, 5, '{-50, 3, -3, 7, 9, 9, -600, 16383});

        // Distance-two reuse of addr 7 across an unrelated beat
        applyStimulus(1, 0, 0, 7, '{0, 0, 0, 10, 1, 1, 1, 1});
        applyStimulus(1, 1, 0, 9, '{4, 4, 4, 4, 4, 4, 4, 4});
        applyStimulus(0, 1, 0, 7, '{0, 0, 0, 20, 2, 2, 2, 2});

        // Positive then negative saturation
        for (int i = 0; i < CH; i++) begin
            pos[i] = 16383;
            neg[i] = -16384;
        end
        for (int k = 0; k < 40; k++) applyStimulus(k == 0, k == 39, 0, 0, pos);
        for (int k = 0; k < 40; k++) applyStimulus(k == 0, k == 39, 0, 1, neg);

        // Skipped middle pass, then a single first+last beat
        applyStimulus(1, 0, 0, 11, '{5, 5, 5, 5, 5, 5, 5, 5});
        applyStimulus(0, 0, 1, 11, '{99, 99, 99, 99, 99, 99, 99, 99});
        applyStimulus(0, 1, 0, 11, '{7, -7, 7, -7, 7, -7, 7, -7});
        applyStimulus(1, 1, 0, 12, '{-3, -3, -3, -3, -3, -3, -3, -3});

        repeat (2) @(posedge clk);
        #1;

        // Random traffic over four addresses with gaps
        for (int i = 0; i < 4; i++) touched[i] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 3);
            for (int i = 0; i < CH; i++) ld[i] = int'($urandom_range(0, 32767)) - 16384;
            applyStimulus(!touched[a] || ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 4) == 0, 20 + a, ld);
            touched[a] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset right behind a last_pass beat discards it
        applyStimulus(1, 1, 0, 30, '{1, 2, 3, 4, 5, 6, 7, 8});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        mdl_ovf = '0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_ovf", ovf_flag, 0);
        repeat (4) @(posedge clk);
        #1;

        applyStimulus(1, 1, 0, 31, '{11, -12, 13, -14, 15, -16, 17, -18});

        // Narrow build: two passes of the same lane data, results doubled
        bvals = '{1, -2, 3, -4};
        in_valid_b   = 1'b1;
        first_pass_b = 1'b1;
        in_addr_b    = 4'd3;
        for (int i = 0; i < 4; i++) in_data_b[i*8 +: 8] = 8'(bvals[i]);
        @(posedge clk);
        #1;
        first_pass_b = 1'b0;
        last_pass_b  = 1'b1;
        eb.addr = 4'd3;
        eb.data = '0;
        for (int i = 0; i < 4; i++) eb.data[i*12 +: 12] = 12'(2 * bvals[i]);
        sb_b.push_back(eb);
        @(posedge clk);
        #1;
        in_valid_b  = 1'b0;
        last_pass_b = 1'b0;

        repeat (8) @(posedge clk);
        #1;
        checkOutput("drain", sb_q.size() + sb_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_acc_array.md
Name: module_acc_array

Overview:
- Parametrised N-channel partial-sum accumulator for the conv datapath; successor to the fixed 8-lane, 15-bit accumulator group.
- Each lane holds a DEPTH-entry partial-sum RAM. Per input pass it adds the incoming PE result to the stored sum for the addressed pixel and writes the new sum back.
- Adds over the 8-lane version:
  - in-pipeline read-after-write forwarding;
  - signed saturation to a wider accumulator;
  - a final-pass output stream with valid;
  - a sticky per-lane overflow flag.

Parameters:
- CH, 8: number of parallel output-channel lanes.
- DW, 15: input data width per lane (signed two's complement).
- AW, 20: accumulator/RAM word width (signed); AW >= DW.
- DEPTH, 114*114: RAM entries per lane.
- ADDR_BIT, 14: address width; 2^ADDR_BIT >= DEPTH.
- SAT_EN, 1: 1 = saturate sums to the AW signed range, 0 = wrap modulo 2^AW.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  an input beat is present this cycle.
- first_pass  in  1  the stored sum is treated as 0 (first input channel).
- last_pass  in  1  the result of this beat is emitted on out_*.
- data_zero  in  1  in_data is treated as 0 for all lanes (skipped/zero input).
- in_addr  in  ADDR_BIT  pixel address.
- in_data  in  CH*DW  lane i is at bits [i*DW +: DW].
- out_valid  out  1  out_data/out_addr are valid.
- out_addr  out  ADDR_BIT  address of the emitted sum.
- out_data  out  CH*AW  final sums; lane i is at bits [i*AW +: AW].
- ovf_flag  out  CH  sticky per-lane saturation/overflow indicator.

Behaviour:
- Reset: out_valid=0, out_addr=0, out_data=0, ovf_flag=0.
  - All pipeline valid bits are cleared and any in-flight beats are discarded: no write-back, no output.
  - RAM contents are not cleared. The first beat to any address after reset must carry first_pass=1.
- No backpressure: a beat is accepted on every cycle in_valid=1.
- Pipeline, three stages:
  - S0: register the beat and issue the RAM read at in_addr.
  - S1: read data returns (1-cycle synchronous RAM read).
  - S2: compute and write back to RAM; register outputs.
- Latency: a beat accepted at cycle t produces its RAM write at the t+2 edge and out_valid=1 during cycle t+3 (when last_pass=1).
- Operand selection (per lane):
  - prev = 0 if first_pass, else the forwarded value, else the RAM read data.
  - cur = 0 if data_zero, else in_data sign-extended to AW.
  - sum = prev + cur, computed in AW+1 bits.
- Saturation (SAT_EN=1): if sum > 2^(AW-1)-1, clamp to that value; if sum < -2^(AW-1), clamp to -2^(AW-1). The lane's ovf_flag bit is set when clamping occurs.
- Wrap (SAT_EN=0): take the low AW bits. ovf_flag is set when the signed result overflows.
- Write-back: the result is always written to RAM at the beat's address, including on last_pass.
- Forwarding (RAM must never return stale data):
  - If the S1 beat address equals the S2 beat address, prev comes from the S2 result being written this cycle.
  - Otherwise, if the S1 address equals the address written in the previous cycle, prev comes from that registered write value.
  - The S2 match has priority over the older write.
- Outputs:
  - out_valid is high for exactly one cycle per last_pass beat.
  - out_data/out_addr hold their values while out_valid=0; downstream must not sample them then.
- ovf_flag clears only on rst.
- in_addr >= DEPTH is undefined; the verifier must not drive it.
- first_pass=1 together with last_pass=1 is legal and emits cur alone.

Test Plan:
- Three beats to addr 5 on consecutive cycles (first, mid, last); lane0 data 100, 200, -50 -> out_valid one cycle 3 cycles after the last beat, out_addr=5, lane0 out=250. This exercises back-to-back forwarding.
- Beats to addr 7, addr 9, addr 7 (second beat to 7 is last, lane3 data 10 then 20) -> lane3 out=30. This exercises distance-2 forwarding.
- SAT_EN=1, AW=20: accumulate +16383 on addr 0 for 40 passes -> out=524287, ovf_flag[i]=1. The same with -16384 -> out=-524288.
- data_zero=1 on a middle pass (data 5, zero, 7) -> out=12. first_pass and last_pass on one beat with data -3 -> out=-3.
- rst asserted one cycle after a last_pass beat -> no out_valid; out_data=0 and ovf_flag=0 the cycle after reset.
- CH=4, DW=8, AW=12 build: distinct per-lane data (1, -2, 3, -4) over two passes, doubled -> out 2, -4, 6, -8 at the correct lane bit offsets.
